// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter.
// Build option: RAM_PORT_ARB_FIXED_PRIO_EN selects fixed priority (A wins) in ram_arb_pick.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RDCAP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection between the two requesters.
// Build option: RAM_PORT_ARB_FIXED_PRIO_EN -> port A always wins a tie and
// last_owner is ignored; otherwise ties go to the port not granted last.
import ram_arb_pkg::*;

module ram_arb_pick (
    input  logic   a_req,
    input  logic   b_req,
    input  owner_t last_owner,
    output owner_t winner
);

    // Single requests win outright; only a tie consults the policy.
    always_comb begin
        winner = OWN_A;
        if (a_req && b_req) begin
`ifdef RAM_PORT_ARB_FIXED_PRIO_EN
            winner = OWN_A;
`else
            winner = (last_owner == OWN_A) ? OWN_B : OWN_A;
`endif
        end else if (b_req) begin
            winner = OWN_B;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port sequencer for the shared single-port RAM: serialises A/B accesses,
// drives the RAM strobes and returns captured read data with a per-port valid.
// Build option: RAM_PORT_ARB_FIXED_PRIO_EN (see ram_arb_pick).
import ram_arb_pkg::*;

module ram_port_arbiter #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state;
    owner_t            owner;
    owner_t            last_owner;
    owner_t            winner;
    logic              op_we;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    ram_arb_pick u_pick (
        .a_req      (a_req),
        .b_req      (b_req),
        .last_owner (last_owner),
        .winner     (winner)
    );

    // Operand mux for whichever port the picker chose this cycle.
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (winner == OWN_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // Sequencer FSM. Every output is a register loaded one cycle ahead, so the
    // requester sees gnt and the RAM sees its strobe in the XFER cycle with no
    // combinational path from req. ram_addr/ram_wdata double as the operand
    // registers and simply hold the last accepted operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_A;
            last_owner <= OWN_B;
            op_we      <= 1'b0;
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            ram_wr_en  <= 1'b0;
            ram_rd_en  <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            ram_wr_en <= 1'b0;
            ram_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        owner      <= winner;
                        last_owner <= winner;
                        op_we      <= sel_we;
                        ram_addr   <= sel_addr;
                        ram_wdata  <= sel_wdata;
                        ram_wr_en  <= sel_we;
                        ram_rd_en  <= ~sel_we;
                        a_gnt      <= (winner == OWN_A);
                        b_gnt      <= (winner == OWN_B);
                        busy       <= 1'b1;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (op_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RDCAP;
                    end
                end
                RDCAP: begin
                    rdata    <= ram_rdata;
                    a_rvalid <= (owner == OWN_A);
                    b_rvalid <= (owner == OWN_B);
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 128x32 RAM model.
import ram_arb_pkg::*;

module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [6:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [6:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
    logic        ram_wr_en, ram_rd_en;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata, rdata;
    logic [31:0] ram_rdata = '0;

    logic [31:0]  mem [128];
    logic [127:0] wr_mask = '0;

    int total = 0;
    int bad   = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .busy(busy),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten words read back as A5000000 | address.
    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_addr]     <= ram_wdata;
            wr_mask[ram_addr] <= 1'b1;
        end
        if (ram_rd_en)
            ram_rdata <= wr_mask[ram_addr] ? mem[ram_addr] : (32'hA500_0000 | {25'h0, ram_addr});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " gnt"},    {30'h0, a_gnt, b_gnt}, 32'h0);
        chk({tag, " rvalid"}, {30'h0, a_rvalid, b_rvalid}, 32'h0);
        chk({tag, " strobes"},{29'h0, busy, ram_wr_en, ram_rd_en}, 32'h0);
        chk({tag, " addr"},   {25'h0, ram_addr}, 32'h0);
        chk({tag, " wdata"},  ram_wdata, 32'h0);
        chk({tag, " rdata"},  rdata, 32'h0);
    endtask

    initial begin
        logic exp_a, exp_b, rr_next_b;

        // Reset
        #12;
        chk_zero("reset");
        rst = 1'b1;
        step();

        // Tie after reset: A write 10, B read 11 -> A first, B two cycles later
        a_req = 1; a_we = 1; a_addr = 7'h10; a_wdata = 32'h0BAD_F00D;
        b_req = 1; b_we = 0; b_addr = 7'h11;
        step();
        chk("tie a_gnt", {31'h0, a_gnt}, 32'h1);
        chk("tie b_gnt0", {31'h0, b_gnt}, 32'h0);
        chk("tie wr_en", {31'h0, ram_wr_en}, 32'h1);
        chk("tie addr10", {25'h0, ram_addr}, 32'h10);
        a_req = 0;
        step();
        chk("tie gap", {30'h0, a_gnt, b_gnt}, 32'h0);
        step();
        chk("tie b_gnt", {31'h0, b_gnt}, 32'h1);
        chk("tie rd_en", {31'h0, ram_rd_en}, 32'h1);
        chk("tie addr11", {25'h0, ram_addr}, 32'h11);
        b_req = 0;
        step();
        chk("tie rdcap busy", {31'h0, busy}, 32'h1);
        step();
        chk("tie b_rvalid", {31'h0, b_rvalid}, 32'h1);
        chk("tie rdata", rdata, 32'hA500_0011);

        // A write alone
        a_req = 1; a_we = 1; a_addr = 7'h05; a_wdata = 32'hDEAD_BEEF;
        step();
        chk("wr a_gnt", {31'h0, a_gnt}, 32'h1);
        chk("wr b_gnt", {31'h0, b_gnt}, 32'h0);
        chk("wr strobes", {30'h0, ram_wr_en, ram_rd_en}, 32'h2);
        chk("wr addr", {25'h0, ram_addr}, 32'h05);
        chk("wr wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("wr busy", {31'h0, busy}, 32'h1);
        a_req = 0;
        step();
        chk("wr T2 busy", {31'h0, busy}, 32'h0);
        chk("wr T2 gnt", {31'h0, a_gnt}, 32'h0);
        chk("wr T2 wr_en", {31'h0, ram_wr_en}, 32'h0);

        // B read of 05
        b_req = 1; b_we = 0; b_addr = 7'h05;
        step();
        chk("rd b_gnt", {31'h0, b_gnt}, 32'h1);
        chk("rd strobes", {30'h0, ram_wr_en, ram_rd_en}, 32'h1);
        chk("rd addr", {25'h0, ram_addr}, 32'h05);
        b_req = 0;
        step();
        chk("rd T2 busy", {31'h0, busy}, 32'h1);
        chk("rd T2 valid", {30'h0, a_rvalid, b_rvalid}, 32'h0);
        step();
        chk("rd b_rvalid", {31'h0, b_rvalid}, 32'h1);
        chk("rd a_rvalid", {31'h0, a_rvalid}, 32'h0);
        chk("rd rdata", rdata, 32'hDEAD_BEEF);
        chk("rd T3 busy", {31'h0, busy}, 32'h0);
        step();
        chk("rd T4 rvalid", {31'h0, b_rvalid}, 32'h0);
        chk("rd T4 hold", rdata, 32'hDEAD_BEEF);

        // Continuous writes from both ports (last grant was B)
        a_req = 1; a_we = 1; a_addr = 7'h20; a_wdata = 32'h1111_1111;
        b_req = 1; b_we = 1; b_addr = 7'h21; b_wdata = 32'h2222_2222;
        rr_next_b = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_a = 0; exp_b = 0;
            if (k % 2 == 0) begin
`ifdef RAM_PORT_ARB_FIXED_PRIO_EN
                exp_a = 1;
`else
                exp_a = ~rr_next_b;
                exp_b = rr_next_b;
                rr_next_b = ~rr_next_b;
`endif
            end
            chk($sformatf("cont a_gnt k%0d", k), {31'h0, a_gnt}, {31'h0, exp_a});
            chk($sformatf("cont b_gnt k%0d", k), {31'h0, b_gnt}, {31'h0, exp_b});
        end
        a_req = 0; b_req = 0;
        step();
        step();

        // Top address write then read, and word 00 untouched
        a_req = 1; a_we = 1; a_addr = 7'h7F; a_wdata = 32'h1234_5678;
        step();
        chk("7F wr addr", {25'h0, ram_addr}, 32'h7F);
        a_req = 0;
        step();
        a_req = 1; a_we = 0; a_addr = 7'h7F;
        step();
        chk("7F rd gnt", {31'h0, a_gnt}, 32'h1);
        a_req = 0;
        step();
        step();
        chk("7F a_rvalid", {31'h0, a_rvalid}, 32'h1);
        chk("7F b_rvalid", {31'h0, b_rvalid}, 32'h0);
        chk("7F rdata", rdata, 32'h1234_5678);
        b_req = 1; b_we = 0; b_addr = 7'h00;
        step();
        b_req = 0;
        step();
        step();
        chk("00 b_rvalid", {31'h0, b_rvalid}, 32'h1);
        chk("00 rdata", rdata, 32'hA500_0000);

        // Reset asserted during RDCAP
        b_req = 1; b_we = 0; b_addr = 7'h05;
        step();
        chk("rst-rd b_gnt", {31'h0, b_gnt}, 32'h1);
        b_req = 0;
        step();
        chk("rst-rd busy", {31'h0, busy}, 32'h1);
        #2 rst = 0;
        #1;
        chk_zero("rst-rd async");
        step();
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst-rd no rvalid %0d", k), {30'h0, a_rvalid, b_rvalid}, 32'h0);
        end
        a_req = 1; a_we = 1; a_addr = 7'h30; a_wdata = 32'h3333_3333;
        b_req = 1; b_we = 1; b_addr = 7'h31; b_wdata = 32'h4444_4444;
        step();
        chk("post-rst a_gnt", {31'h0, a_gnt}, 32'h1);
        chk("post-rst b_gnt", {31'h0, b_gnt}, 32'h0);
        a_req = 0; b_req = 0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the shared 128x32 single-port RAM. Port A is the RS232 packet decoder (write/read commands from 8-byte frames); port B is the AES engine fetching key/plaintext words. The block serialises accesses, drives the RAM strobes, captures read data, and returns it with a per-port valid pulse.

## Interface
- ADDR_W, 7, RAM word address width (128 words)
- DATA_W, 32, RAM data width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- a_req  in  1  port A request, held until a_gnt
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  port A grant pulse (operands sampled)
- a_rvalid  out  1  port A read-data valid pulse
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid: same as port A, for port B
- rdata  out  DATA_W  read data, shared, valid with a_rvalid/b_rvalid
- busy  out  1  FSM not in IDLE
- ram_wr_en  out  1  RAM write strobe
- ram_rd_en  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_rd_en

## Operation
- States: IDLE, XFER, RDCAP.
- IDLE: no request -> stay. Any req -> pick winner, latch winner's we/addr/wdata into operand registers, record owner, -> XFER.
- XFER: ram_addr/ram_wdata from operand registers; ram_wr_en = we, ram_rd_en = ~we; owner's gnt = 1. Write -> IDLE; read -> RDCAP.
- RDCAP: capture ram_rdata into rdata, set owner's rvalid for the next cycle, -> IDLE.
- Round-robin: last_owner register, reset value B, so A wins the first tie. Simultaneous requests -> grant the port not granted last. Single request -> grant it regardless of pointer.
- Requester holds req and operands until gnt; req still high in the cycle after gnt is a new request.
- Same-address write/read from both ports is serialised in grant order; no forwarding.
- Address is taken modulo 2^ADDR_W; no range check.
- Reset (rst low, any state): state IDLE, last_owner B; all outputs 0 (gnt, rvalid, strobes, ram_addr, ram_wdata, rdata, busy). Pending read is dropped and no rvalid is issued.

## Timing
- All outputs are registered or Moore-decoded from state/registers; no combinational req->gnt path.
- Write: req seen in IDLE at T0 -> gnt + ram_wr_en at T1 -> IDLE at T2. Cost 2 cycles.
- Read: gnt + ram_rd_en at T1 -> RDCAP at T2 -> rvalid + rdata at T3, FSM in IDLE at T3 and may accept a new request the same cycle. Cost 3 cycles.
- gnt and rvalid are exactly one cycle wide; rdata holds until the next capture.
- busy = 1 in XFER and RDCAP.

## Configuration
- RAM_PORT_ARB_FIXED_PRIO_EN defined: port A always wins ties, and last_owner is unused. Port B can starve under continuous A traffic; this is accepted.
- Not defined: round-robin as above.

## Structure
- Package ram_arb_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, XFER, RDCAP), owner encoding (OWN_A = 0, OWN_B = 1).
- One sub-module, ram_arb_pick: inputs a_req, b_req, last_owner; output winner. Holds the round-robin/fixed-priority logic selected by the macro.
- The top module holds the FSM, operand registers, and rdata capture.

## Test plan
- A write alone: a_we = 1, a_addr = 7'h05, a_wdata = 32'hDEADBEEF -> a_gnt, ram_wr_en, ram_addr = 05, ram_wdata = DEADBEEF, all at T1; busy low at T2.
- B read of 7'h05 after the above write (RAM model) -> b_gnt + ram_rd_en at T1; b_rvalid = 1 with rdata = DEADBEEF at T3; a_rvalid stays 0.
- Both requests at T0 after reset, A write 7'h10, B read 7'h11 -> A granted first. B gnt two cycles after a_gnt. Grant order A, B.
- A and B held continuously with writes -> grants alternate A, B, A, B; with RAM_PORT_ARB_FIXED_PRIO_EN -> only A granted while a_req is high.
- rst low during RDCAP -> all outputs 0 immediately; no rvalid after release; next request is granted normally, and A wins a tie.
- Address 7'h7F write, then read of 7'h7F -> correct data with no wrap into 7'h00.
